// File: rtl/snake_pkg.sv
// snake_pkg: shared codes, grid geometry and init image for the snake game controller.
package snake_pkg;
    localparam logic [1:0] ST_RUN  = 2'b00;
    localparam logic [1:0] ST_DIE  = 2'b01;
    localparam logic [1:0] ST_INIT = 2'b10;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_HEAD  = 3'd1;
    localparam logic [2:0] PH_CHECK = 3'd2;
    localparam logic [2:0] PH_MOVE  = 3'd3;
    localparam logic [2:0] PH_FOOD  = 3'd4;

    localparam int GRID_W = 32;
    localparam int GRID_H = 24;

    localparam logic [4:0] INIT_X   = 5'd16;
    localparam logic [4:0] INIT_Y   = 5'd12;
    localparam logic [5:0] INIT_LEN = 6'd3;
    localparam logic [4:0] FOOD_X0  = 5'd24;
    localparam logic [4:0] FOOD_Y0  = 5'd12;

    // Direction codes pair up so the reverse differs only in bit 0.
    function automatic logic [1:0] opposite(input logic [1:0] d);
        return d ^ 2'b01;
    endfunction
endpackage

// File: rtl/snake_game_ctrl_food_lfsr.sv
// food_lfsr: free-running 10-bit LFSR (x^10+x^7+1) mapped to an in-grid food candidate.
module food_lfsr
    import snake_pkg::*;
(
    input  logic       clk,
    input  logic       clrn,
    output logic [4:0] cand_x_o,
    output logic [4:0] cand_y_o
);
    logic [9:0] lfsr_q, lfsr_d;

    assign lfsr_d   = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    assign cand_x_o = lfsr_q[4:0];
    assign cand_y_o = lfsr_q[9:5] >= 5'(GRID_H) ? lfsr_q[9:5] - 5'd8 : lfsr_q[9:5];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) lfsr_q <= 10'h001;
        else       lfsr_q <= lfsr_d;
    end
endmodule

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game sequencer; each tick runs head, collision scan, move and food
// placement phases over a 64-entry body held in registers.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_CYCLES = 25_000_000,
    parameter int MAX_LEN     = 63
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         btn_start,
    input  logic         dir_valid,
    input  logic [1:0]   dir_in,
    output logic [1:0]   game_state,
    output logic [319:0] snake_x_1dim,
    output logic [319:0] snake_y_1dim,
    output logic [5:0]   snake_length,
    output logic [4:0]   food_x,
    output logic [4:0]   food_y
);
    localparam int TW = $clog2(TICK_CYCLES);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [5:0] LEN_CAP = 6'(MAX_LEN);

    logic [1:0]    state_q, state_d, cur_dir_q, cur_dir_d, pend_dir_q, pend_dir_d;
    logic [2:0]    phase_q, phase_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          btn_q, eat_q, eat_d;
    logic [4:0]    seg_x_q [64];
    logic [4:0]    seg_x_d [64];
    logic [4:0]    seg_y_q [64];
    logic [4:0]    seg_y_d [64];
    logic [5:0]    len_q, len_d, j_q, j_d, last_j;
    logic [4:0]    food_x_q, food_x_d, food_y_q, food_y_d;
    logic [4:0]    nh_x_q, nh_x_d, nh_y_q, nh_y_d;
    logic [4:0]    cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic [4:0]    lfsr_x, lfsr_y, hx, hy, nx, ny;
    logic          wall, start, seg_hit, cand_hit;

    food_lfsr u_lfsr (.clk(clk), .clrn(clrn), .cand_x_o(lfsr_x), .cand_y_o(lfsr_y));

    assign hx       = seg_x_q[0];
    assign hy       = seg_y_q[0];
    assign nx       = cur_dir_q == DIR_RIGHT ? hx + 5'd1 : cur_dir_q == DIR_LEFT ? hx - 5'd1 : hx;
    assign ny       = cur_dir_q == DIR_DOWN ? hy + 5'd1 : cur_dir_q == DIR_UP ? hy - 5'd1 : hy;
    assign wall     = (cur_dir_q == DIR_LEFT && hx == 5'd0) || (cur_dir_q == DIR_RIGHT && hx == 5'(GRID_W - 1))
                   || (cur_dir_q == DIR_UP && hy == 5'd0) || (cur_dir_q == DIR_DOWN && hy == 5'(GRID_H - 1));
    assign start    = btn_start && !btn_q && state_q != ST_RUN;
    assign seg_hit  = seg_x_q[j_q] == nh_x_q && seg_y_q[j_q] == nh_y_q;
    assign cand_hit = seg_x_q[j_q] == cand_x_q && seg_y_q[j_q] == cand_y_q;
    // An eaten step keeps the tail in place, so it must be scanned too.
    assign last_j   = eat_q ? len_q - 6'd1 : len_q - 6'd2;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        tick_d     = tick_q;
        cur_dir_d  = cur_dir_q;
        pend_dir_d = pend_dir_q;
        seg_x_d    = seg_x_q;
        seg_y_d    = seg_y_q;
        len_d      = len_q;
        j_d        = j_q;
        food_x_d   = food_x_q;
        food_y_d   = food_y_q;
        nh_x_d     = nh_x_q;
        nh_y_d     = nh_y_q;
        eat_d      = eat_q;
        cand_x_d   = cand_x_q;
        cand_y_d   = cand_y_q;
        if (dir_valid && dir_in != opposite(cur_dir_q)) pend_dir_d = dir_in;
        if (start) begin
            state_d    = ST_RUN;
            phase_d    = PH_IDLE;
            tick_d     = '0;
            cur_dir_d  = DIR_RIGHT;
            pend_dir_d = DIR_RIGHT;
            for (int i = 0; i < 64; i++) begin
                seg_x_d[i] = i < 3 ? INIT_X - 5'(i) : 5'd0;
                seg_y_d[i] = i < 3 ? INIT_Y : 5'd0;
            end
            len_d    = INIT_LEN;
            food_x_d = FOOD_X0;
            food_y_d = FOOD_Y0;
        end else if (state_q == ST_RUN) begin
            case (phase_q)
                PH_IDLE: begin
                    tick_d = tick_q == TICK_LAST ? '0 : tick_q + TW'(1);
                    if (tick_q == TICK_LAST) begin
                        phase_d   = PH_HEAD;
                        cur_dir_d = pend_dir_q;
                    end
                end
                PH_HEAD: begin
                    state_d = wall ? ST_DIE : ST_RUN;
                    phase_d = wall ? PH_IDLE : PH_CHECK;
                    nh_x_d  = nx;
                    nh_y_d  = ny;
                    eat_d   = nx == food_x_q && ny == food_y_q;
                    j_d     = '0;
                end
                PH_CHECK: begin
                    state_d = seg_hit ? ST_DIE : ST_RUN;
                    phase_d = seg_hit ? PH_IDLE : j_q == last_j ? PH_MOVE : PH_CHECK;
                    j_d     = j_q + 6'd1;
                end
                PH_MOVE: begin
                    for (int i = 63; i > 0; i--) begin
                        seg_x_d[i] = seg_x_q[i-1];
                        seg_y_d[i] = seg_y_q[i-1];
                    end
                    seg_x_d[0] = nh_x_q;
                    seg_y_d[0] = nh_y_q;
                    len_d      = eat_q && len_q < LEN_CAP ? len_q + 6'd1 : len_q;
                    phase_d    = eat_q ? PH_FOOD : PH_IDLE;
                    cand_x_d   = lfsr_x;
                    cand_y_d   = lfsr_y;
                    j_d        = '0;
                end
                PH_FOOD: begin
                    cand_x_d = cand_hit ? lfsr_x : cand_x_q;
                    cand_y_d = cand_hit ? lfsr_y : cand_y_q;
                    j_d      = cand_hit ? 6'd0 : j_q + 6'd1;
                    if (!cand_hit && j_q == len_q - 6'd1) begin
                        food_x_d = cand_x_q;
                        food_y_d = cand_y_q;
                        phase_d  = PH_IDLE;
                    end
                end
                default: phase_d = PH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= ST_INIT;
            phase_q    <= PH_IDLE;
            tick_q     <= '0;
            cur_dir_q  <= DIR_RIGHT;
            pend_dir_q <= DIR_RIGHT;
            btn_q      <= 1'b0;
            for (int i = 0; i < 64; i++) begin
                seg_x_q[i] <= i < 3 ? INIT_X - 5'(i) : 5'd0;
                seg_y_q[i] <= i < 3 ? INIT_Y : 5'd0;
            end
            len_q    <= INIT_LEN;
            j_q      <= '0;
            food_x_q <= FOOD_X0;
            food_y_q <= FOOD_Y0;
            nh_x_q   <= '0;
            nh_y_q   <= '0;
            eat_q    <= 1'b0;
            cand_x_q <= '0;
            cand_y_q <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            tick_q     <= tick_d;
            cur_dir_q  <= cur_dir_d;
            pend_dir_q <= pend_dir_d;
            btn_q      <= btn_start;
            seg_x_q    <= seg_x_d;
            seg_y_q    <= seg_y_d;
            len_q      <= len_d;
            j_q        <= j_d;
            food_x_q   <= food_x_d;
            food_y_q   <= food_y_d;
            nh_x_q     <= nh_x_d;
            nh_y_q     <= nh_y_d;
            eat_q      <= eat_d;
            cand_x_q   <= cand_x_d;
            cand_y_q   <= cand_y_d;
        end
    end

    for (genvar i = 0; i < 64; i++) begin : g_pack
        assign snake_x_1dim[5*i +: 5] = seg_x_q[i];
        assign snake_y_1dim[5*i +: 5] = seg_y_q[i];
    end

    assign game_state   = state_q;
    assign snake_length = len_q;
    assign food_x       = food_x_q;
    assign food_y       = food_y_q;
endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: directed bench for snake_game_ctrl with a short tick period.
module tb_snake_game_ctrl;
    logic         clk = 1'b0;
    logic         clrn = 1'b0;
    logic         btn_start = 1'b0;
    logic         dir_valid = 1'b0;
    logic [1:0]   dir_in = 2'b00;
    logic [1:0]   game_state;
    logic [319:0] snake_x_1dim, snake_y_1dim;
    logic [5:0]   snake_length;
    logic [4:0]   food_x, food_y;
    int n_vec = 0;
    int n_err = 0;

    localparam int BOUND = 5000;

    snake_game_ctrl #(.TICK_CYCLES(256), .MAX_LEN(63)) dut (
        .clk(clk), .clrn(clrn), .btn_start(btn_start), .dir_valid(dir_valid), .dir_in(dir_in),
        .game_state(game_state), .snake_x_1dim(snake_x_1dim), .snake_y_1dim(snake_y_1dim),
        .snake_length(snake_length), .food_x(food_x), .food_y(food_y)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] sx(input int i);
        return snake_x_1dim[5*i +: 5];
    endfunction

    function automatic logic [4:0] sy(input int i);
        return snake_y_1dim[5*i +: 5];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_seg(input string tag, input int i, input int x, input int y);
        chk({tag, ".x"}, 32'(sx(i)), 32'(x));
        chk({tag, ".y"}, 32'(sy(i)), 32'(y));
    endtask

    task automatic chk_food_free(input string tag, input int hx, input int n);
        logic ok;
        ok = food_y <= 5'd23 && !(food_x == 5'd0 && food_y == 5'd0);
        for (int i = 0; i < n; i++) if (food_x == 5'(hx - i) && food_y == 5'd12) ok = 1'b0;
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_step(input string tag);
        logic [11:0] snap;
        int n;
        snap = {game_state, sx(0), sy(0)};
        n = 0;
        while ({game_state, sx(0), sy(0)} === snap && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".timeout"}, 32'(n < BOUND), 32'd1);
    endtask

    task automatic wait_food(input string tag);
        logic [9:0] snap;
        int n;
        snap = {food_x, food_y};
        n = 0;
        while ({food_x, food_y} === snap && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".timeout"}, 32'(n < BOUND), 32'd1);
    endtask

    task automatic dir_pulse(input logic [1:0] d);
        dir_valid = 1'b1;
        dir_in = d;
        @(negedge clk);
        dir_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic start_pulse();
        btn_start = 1'b1;
        @(negedge clk);
        btn_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic restart();
        clrn = 1'b0;
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        start_pulse();
    endtask

    task automatic hold_len(input logic [5:0] v);
        force dut.len_q = v;
        repeat (2) @(negedge clk);
        release dut.len_q;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst.state", 32'(game_state), 32'd2);
        chk_seg("rst.head", 0, 16, 12);
        chk_seg("rst.seg2", 2, 14, 12);
        chk_seg("rst.seg3", 3, 0, 0);
        chk("rst.len", 32'(snake_length), 32'd3);
        chk("rst.food_x", 32'(food_x), 32'd24);
        chk("rst.food_y", 32'(food_y), 32'd12);
        clrn = 1'b1;
        repeat (300) @(negedge clk);
        chk("idle.state", 32'(game_state), 32'd2);
        chk_seg("idle.head", 0, 16, 12);

        start_pulse();
        chk("start.state", 32'(game_state), 32'd0);
        chk_seg("start.head", 0, 16, 12);
        chk("start.len", 32'(snake_length), 32'd3);
        wait_step("tick1");
        chk_seg("tick1.head", 0, 17, 12);
        chk_seg("tick1.seg2", 2, 15, 12);

        dir_pulse(2'b11);
        wait_step("rev_only");
        chk_seg("rev_only.head", 0, 18, 12);
        dir_pulse(2'b11);
        dir_pulse(2'b00);
        wait_step("rev_then_up");
        chk_seg("rev_then_up.head", 0, 18, 11);
        chk_seg("rev_then_up.seg1", 1, 18, 12);
        dir_pulse(2'b01);
        wait_step("rev_down");
        chk_seg("rev_down.head", 0, 18, 10);

        repeat (100) @(negedge clk);
        clrn = 1'b0;
        #1;
        chk("abort.state", 32'(game_state), 32'd2);
        chk_seg("abort.head", 0, 16, 12);
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        start_pulse();
        for (int k = 0; k < 7; k++) wait_step("eat.walk");
        chk_seg("eat.pre_head", 0, 23, 12);
        chk("eat.pre_len", 32'(snake_length), 32'd3);
        wait_step("eat.step");
        chk_seg("eat.head", 0, 24, 12);
        chk("eat.len", 32'(snake_length), 32'd4);
        chk_seg("eat.tail", 3, 21, 12);
        wait_food("eat.food");
        chk_food_free("eat.food_free", 24, 4);

        restart();
        dir_pulse(2'b00);
        for (int k = 0; k < 12; k++) wait_step("wall.walk");
        chk("wall.pre_state", 32'(game_state), 32'd0);
        chk_seg("wall.pre_head", 0, 16, 0);
        wait_step("wall.die");
        chk("wall.state", 32'(game_state), 32'd1);
        chk_seg("wall.head", 0, 16, 0);
        chk_seg("wall.seg1", 1, 16, 1);
        chk("wall.len", 32'(snake_length), 32'd3);
        btn_start = 1'b1;
        dir_valid = 1'b1;
        dir_in = 2'b00;
        @(negedge clk);
        btn_start = 1'b0;
        dir_valid = 1'b0;
        @(negedge clk);
        chk("restart.state", 32'(game_state), 32'd0);
        chk_seg("restart.head", 0, 16, 12);
        chk("restart.food_x", 32'(food_x), 32'd24);
        wait_step("restart.step");
        chk_seg("restart.head2", 0, 17, 12);

        restart();
        hold_len(6'd5);
        chk("self.len", 32'(snake_length), 32'd5);
        wait_step("self.r1");
        wait_step("self.r2");
        chk_seg("self.seg4", 4, 14, 12);
        dir_pulse(2'b00);
        wait_step("self.up");
        dir_pulse(2'b11);
        wait_step("self.left");
        chk_seg("self.pre_head", 0, 17, 11);
        dir_pulse(2'b01);
        wait_step("self.down");
        chk("self.state", 32'(game_state), 32'd1);
        chk_seg("self.head", 0, 17, 11);
        chk_seg("self.seg3", 3, 17, 12);
        chk_seg("self.seg4b", 4, 16, 12);
        chk("self.len_hold", 32'(snake_length), 32'd5);

        restart();
        hold_len(6'd63);
        for (int k = 0; k < 8; k++) wait_step("cap.walk");
        chk_seg("cap.head", 0, 24, 12);
        chk("cap.len", 32'(snake_length), 32'd63);
        chk_seg("cap.seg1", 1, 23, 12);
        chk_seg("cap.seg10", 10, 14, 12);
        chk_seg("cap.seg11", 11, 0, 0);
        wait_food("cap.food");
        chk_food_free("cap.food_free", 24, 11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
